sram_audio_arbiter: RTL

Shares the single external 16-bit SRAM between two requesters and sequences every SRAM cycle. Port A is the audio sample streamer: time-critical, read-only, given priority. Port B is a general client, such as the note-chart fetcher or the sample loader. The block owns all SRAM control pins and the DQ tristate, so no other module drives the SRAM.

---
 rtl/sram_audio_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sram_audio_arbiter.sv
// rtl/sram_audio_arbiter.sv - two-port arbiter and cycle sequencer for the shared external SRAM
//
// Purpose: shares one 16-bit asynchronous SRAM between the audio sample
// streamer (port A, read-only, priority) and a general client (port B).
// Every transfer is IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE.
// The block owns every SRAM control pin and the DQ tristate.
//
// Build option: define SRAM_ARB_WRITE_EN to support B-port writes. Without
// it every B transfer is a read, SRAM_WE_N is tied high and DQ is never driven.
//
// Ports:
//   CLK, RESET               clock, asynchronous active-high reset
//   a_req/a_addr             A read request (held until a_ack)
//   a_ack/a_rdata            A completion pulse, registered read data
//   b_req/b_we/b_addr/b_wdata B request, write flag, address, write data
//   b_ack/b_rdata            B completion pulse, registered read data
//   busy                     high whenever the sequencer is not idle
//   SRAM_*                   external SRAM address, data and control pins
module sram_audio_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [2:0] LAST_WAIT  = 3'(WAIT_CYCLES - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q,   state_d;
    logic [2:0]        wait_q,    wait_d;
    logic              owner_b_q, owner_b_d;
    logic              write_q,   write_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              oe_n_q,    oe_n_d;
    logic              a_ack_q,   a_ack_d;
    logic              b_ack_q,   b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic [3:0]        starve_q,  starve_d;

    logic grant;
    logic b_wins;
    logic grant_we;

    // A keeps priority until B has been passed over STARVE_MAX times in a row.
    assign b_wins = b_req && (!a_req || (starve_q == STARVE_LIM));
    assign grant  = (state_q == S_IDLE) && (a_req || b_req);

`ifdef SRAM_ARB_WRITE_EN
    logic              we_n_q,  we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    assign grant_we = b_wins && b_we;

    // WE_N is low for exactly the ACCESS cycles; DQ stays driven through
    // DONE so the data is held past the WE_N rising edge.
    always_comb begin
        we_n_d  = we_n_q;
        dq_oe_d = dq_oe_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    we_n_d  = !grant_we;
                    dq_oe_d = grant_we;
                    wdata_d = b_wdata;
                end
            end
            S_ACCESS: begin
                if (wait_q == LAST_WAIT) begin
                    we_n_d = 1'b1;
                end
            end
            default: begin
                dq_oe_d = 1'b0;
            end
        endcase
    end

    assign SRAM_WE_N = we_n_q;
    assign SRAM_DQ   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
`else
    logic unused_write_inputs;

    assign grant_we            = 1'b0;
    assign SRAM_WE_N           = 1'b1;
    assign SRAM_DQ             = {DATA_W{1'bz}};
    assign unused_write_inputs = ^{b_we, b_wdata};
`endif

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        owner_b_d = owner_b_q;
        write_d   = write_q;
        addr_d    = addr_q;
        oe_n_d    = oe_n_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d   = S_ACCESS;
                    wait_d    = 3'd0;
                    owner_b_d = b_wins;
                    write_d   = grant_we;
                    addr_d    = b_wins ? b_addr : a_addr;
                    oe_n_d    = grant_we;
                end
            end
            S_ACCESS: begin
                if (wait_q == LAST_WAIT) begin
                    state_d = S_DONE;
                    oe_n_d  = 1'b1;
                    a_ack_d = !owner_b_q;
                    b_ack_d = owner_b_q;
                    // Read data is taken at the end of the last ACCESS cycle,
                    // while OE_N is still low.
                    if (!write_q) begin
                        if (owner_b_q) begin
                            b_rdata_d = SRAM_DQ;
                        end else begin
                            a_rdata_d = SRAM_DQ;
                        end
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!b_req) begin
            starve_d = 4'd0;
        end else if (grant && b_wins) begin
            starve_d = 4'd0;
        end else if (grant && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            wait_q    <= 3'd0;
            owner_b_q <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            oe_n_q    <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            starve_q  <= 4'd0;
`ifdef SRAM_ARB_WRITE_EN
            we_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
            wdata_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            owner_b_q <= owner_b_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            oe_n_q    <= oe_n_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            starve_q  <= starve_d;
`ifdef SRAM_ARB_WRITE_EN
            we_n_q    <= we_n_d;
            dq_oe_q   <= dq_oe_d;
            wdata_q   <= wdata_d;
`endif
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign SRAM_ADDR = addr_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
